// File: rtl/seven_seg_pkg.sv
// rtl/seven_seg_pkg.sv - segment types and active-low hex decode shared by display blocks
package seven_seg_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_BLANK = 7'h7F;

  // Active-low {g,f,e,d,c,b,a} patterns for 0..F
  function automatic seg_t hex_to_seg(input logic [3:0] hex);
    seg_t s;
    case (hex)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seven_seg_scan_n_if.sv
// rtl/seven_seg_scan_n_if.sv - value/control inputs and pin-side outputs of the scanner
interface seven_seg_scan_n_if #(
  parameter int NUM_DIGITS = 8,
  parameter int BRIGHT_W   = 4
);
  import seven_seg_pkg::*;

  logic [4*NUM_DIGITS-1:0] value;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic [NUM_DIGITS-1:0]   digit_en;
  logic                    lz_blank;
  logic [BRIGHT_W-1:0]     brightness;
  logic                    disp_on;
  logic [NUM_DIGITS-1:0]   anodes;
  seg_t                    seg;
  logic                    dp;
  logic                    frame_start;

  modport master (
    output value, dp_in, digit_en, lz_blank, brightness, disp_on,
    input  anodes, seg, dp, frame_start
  );

  modport slave (
    input  value, dp_in, digit_en, lz_blank, brightness, disp_on,
    output anodes, seg, dp, frame_start
  );

endinterface

// File: rtl/seven_seg_decoder.sv
// rtl/seven_seg_decoder.sv - combinational hex to active-low segments with blank override
module seven_seg_decoder
  import seven_seg_pkg::*;
(
  input  logic [3:0] hex,
  input  logic       blank,
  output seg_t       seg
);

  assign seg = blank ? SEG_BLANK : hex_to_seg(hex);

endmodule

// File: rtl/seven_seg_scan_n.sv
// rtl/seven_seg_scan_n.sv - N-digit multiplexed seven-segment scanner with snapshot, LZ blanking and PWM
module seven_seg_scan_n
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS   = 8,
  parameter int SLOT_LOG2    = 17,
  parameter int BLANK_CYCLES = 64,
  parameter int BRIGHT_W     = 4
) (
  input logic               clk,
  input logic               rst,
  seven_seg_scan_n_if.slave bus
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [IDX_W-1:0]     IDX_LAST    = IDX_W'(NUM_DIGITS - 1);
  localparam logic [SLOT_LOG2-1:0] BLANK_START = SLOT_LOG2'(BLANK_CYCLES);

  logic [SLOT_LOG2-1:0]    slot_cnt;
  logic [IDX_W-1:0]        idx;
  logic [4*NUM_DIGITS-1:0] value_snap;
  logic [NUM_DIGITS-1:0]   dp_snap;
  logic [NUM_DIGITS-1:0]   en_snap;
  logic                    lz_snap;

  logic take;
  assign take = (idx == '0) && (slot_cnt == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_cnt <= '0;
      idx      <= '0;
    end else begin
      slot_cnt <= slot_cnt + 1'b1;
      if (slot_cnt == '1)
        idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      value_snap <= '0;
      dp_snap    <= '0;
      en_snap    <= '0;
      lz_snap    <= 1'b0;
    end else if (take) begin
      value_snap <= bus.value;
      dp_snap    <= bus.dp_in;
      en_snap    <= bus.digit_en;
      lz_snap    <= bus.lz_blank;
    end
  end

  // In the snapshot cycle the registers still hold the old frame, so digit 0 reads the live inputs
  logic [4*NUM_DIGITS-1:0] value_cur;
  logic [NUM_DIGITS-1:0]   dp_cur;
  logic [NUM_DIGITS-1:0]   en_cur;
  logic                    lz_cur;

  always_comb begin
    value_cur = take ? bus.value    : value_snap;
    dp_cur    = take ? bus.dp_in    : dp_snap;
    en_cur    = take ? bus.digit_en : en_snap;
    lz_cur    = take ? bus.lz_blank : lz_snap;
  end

  logic [NUM_DIGITS:0]   zero_from;
  logic [NUM_DIGITS-1:0] lz_mask;

  always_comb begin
    zero_from             = '0;
    lz_mask               = '0;
    zero_from[NUM_DIGITS] = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_from[i] = (value_cur[4*i +: 4] == 4'h0) && zero_from[i+1];
      lz_mask[i]   = lz_cur && zero_from[i] && (i > 0);
    end
  end

  logic [3:0]            cur_hex;
  logic                  cur_dp;
  logic                  cur_en;
  logic                  cur_blank;
  logic [NUM_DIGITS-1:0] onehot;

  always_comb begin
    cur_hex   = 4'h0;
    cur_dp    = 1'b0;
    cur_en    = 1'b0;
    cur_blank = 1'b0;
    onehot    = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == IDX_W'(i)) begin
        cur_hex   = value_cur[4*i +: 4];
        cur_dp    = dp_cur[i];
        cur_en    = en_cur[i];
        cur_blank = lz_mask[i];
        onehot[i] = 1'b1;
      end
    end
  end

  seg_t cur_seg;

  seven_seg_decoder u_dec (
    .hex   (cur_hex),
    .blank (cur_blank),
    .seg   (cur_seg)
  );

  logic [BRIGHT_W-1:0] phase;
  logic                anode_on;

  assign phase    = slot_cnt[SLOT_LOG2-1 -: BRIGHT_W];
  assign anode_on = bus.disp_on && cur_en && (slot_cnt >= BLANK_START) && (phase <= bus.brightness);

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.anodes      <= '1;
      bus.seg         <= SEG_BLANK;
      bus.dp          <= 1'b1;
      bus.frame_start <= 1'b0;
    end else begin
      bus.anodes      <= anode_on ? ~onehot : '1;
      bus.seg         <= anode_on ? cur_seg : SEG_BLANK;
      bus.dp          <= anode_on ? ~cur_dp : 1'b1;
      bus.frame_start <= take;
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_n.sv
// tb/tb_seven_seg_scan_n.sv - directed scoreboard bench for the 4-digit and 3-digit scanner
module tb_seven_seg_scan_n;
  import seven_seg_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic rst3;

  always #5 clk = ~clk;

  seven_seg_scan_n_if #(.NUM_DIGITS(4), .BRIGHT_W(2)) if4 ();
  seven_seg_scan_n_if #(.NUM_DIGITS(3), .BRIGHT_W(2)) if3 ();

  seven_seg_scan_n #(.NUM_DIGITS(4), .SLOT_LOG2(4), .BLANK_CYCLES(2), .BRIGHT_W(2)) u4 (
    .clk (clk),
    .rst (rst),
    .bus (if4)
  );

  seven_seg_scan_n #(.NUM_DIGITS(3), .SLOT_LOG2(4), .BLANK_CYCLES(2), .BRIGHT_W(2)) u3 (
    .clk (clk),
    .rst (rst3),
    .bus (if3)
  );

  int checks = 0;
  int errors = 0;

  seg_t       exp_seg [4];
  logic [3:0] exp_en;
  logic [3:0] exp_dp;
  logic [1:0] exp_bright;
  logic       exp_on;

  logic [12:0] sb_q [$];
  localparam logic [12:0] DARK = {4'hF, 7'h7F, 1'b1, 1'b0};

  // Packed {anodes(4), seg, dp, frame_start}; slot t of a frame: digit t/16, slot cycle t%16
  function automatic logic [12:0] expect_at(input int t);
    int d;
    int c;
    logic on;
    logic [3:0] an;
    d  = t / 16;
    c  = t % 16;
    on = exp_on && exp_en[d] && (c >= 2) && ((c / 4) <= int'(exp_bright));
    an = 4'hF;
    if (on) an[d] = 1'b0;
    return {an, on ? exp_seg[d] : 7'h7F, on ? ~exp_dp[d] : 1'b1, (t == 0)};
  endfunction

  task automatic check_out(input int sel, input string tag, input int t, input logic [12:0] expv);
    logic [12:0] obs;
    if (sel == 1) obs = {1'b1, if3.anodes, if3.seg, if3.dp, if3.frame_start};
    else          obs = {if4.anodes, if4.seg, if4.dp, if4.frame_start};
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s t=%0d observed=%h expected=%h", tag, t, obs, expv);
    end
  endtask

  task automatic run_span(input int sel, input string tag, input int t0, input int t1);
    for (int t = t0; t <= t1; t++) sb_q.push_back(expect_at(t));
    for (int t = t0; t <= t1; t++) begin
      @(posedge clk);
      @(negedge clk);
      check_out(sel, tag, t, sb_q.pop_front());
    end
  endtask

  task automatic set_segs(input seg_t s0, input seg_t s1, input seg_t s2, input seg_t s3);
    exp_seg[0] = s0;
    exp_seg[1] = s1;
    exp_seg[2] = s2;
    exp_seg[3] = s3;
  endtask

  initial begin
    rst  = 1'b1;
    rst3 = 1'b1;
    if4.value = '0; if4.dp_in = '0; if4.digit_en = 4'hF; if4.lz_blank = 1'b0;
    if4.brightness = 2'd3; if4.disp_on = 1'b1;
    if3.value = '0; if3.dp_in = '0; if3.digit_en = 3'h7; if3.lz_blank = 1'b0;
    if3.brightness = 2'd3; if3.disp_on = 1'b1;
    exp_en = 4'hF; exp_dp = 4'h0; exp_bright = 2'd3; exp_on = 1'b1;
    set_segs(7'h7F, 7'h7F, 7'h7F, 7'h7F);

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_out(0, "reset4", 0, DARK);

    if4.value = 16'h1A3F;
    set_segs(7'h0E, 7'h30, 7'h08, 7'h79);
    rst = 1'b0;
    run_span(0, "hex", 0, 63);

    if4.value = 16'h0050; if4.lz_blank = 1'b1;
    set_segs(7'h40, 7'h12, 7'h7F, 7'h7F);
    run_span(0, "lz_0050", 0, 63);

    if4.value = 16'h0000;
    set_segs(7'h40, 7'h7F, 7'h7F, 7'h7F);
    run_span(0, "lz_zero", 0, 63);

    if4.value = 16'h1111; if4.lz_blank = 1'b0;
    set_segs(7'h79, 7'h79, 7'h79, 7'h79);
    run_span(0, "snap_pre", 0, 31);
    if4.value = 16'h2222;
    run_span(0, "snap_mid", 32, 63);
    set_segs(7'h24, 7'h24, 7'h24, 7'h24);
    run_span(0, "snap_new", 0, 63);

    if4.brightness = 2'd0; exp_bright = 2'd0;
    run_span(0, "bright0", 0, 63);
    if4.brightness = 2'd1; exp_bright = 2'd1;
    run_span(0, "bright1", 0, 63);

    if4.brightness = 2'd3; exp_bright = 2'd3;
    if4.disp_on = 1'b0; exp_on = 1'b0;
    run_span(0, "disp_off", 0, 63);
    run_span(0, "disp_off2", 0, 39);
    if4.disp_on = 1'b1; exp_on = 1'b1;
    run_span(0, "disp_back", 40, 63);

    if4.digit_en = 4'b1011; if4.dp_in = 4'b0010;
    exp_en = 4'b1011; exp_dp = 4'b0010;
    run_span(0, "en_dp", 0, 63);

    check_out(1, "reset3", 0, DARK);
    if3.value = 12'h456;
    set_segs(7'h02, 7'h12, 7'h19, 7'h7F);
    exp_en = 4'b0111; exp_dp = 4'b0000;
    rst3 = 1'b0;
    run_span(1, "scan3", 0, 47);
    run_span(1, "wrap3", 0, 24);

    rst3 = 1'b1;
    if3.value = 12'h789;
    @(posedge clk);
    @(negedge clk);
    check_out(1, "rst_mid3", 0, DARK);
    rst3 = 1'b0;
    set_segs(7'h10, 7'h00, 7'h78, 7'h7F);
    run_span(1, "restart3", 0, 47);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seven_seg_scan_n.md
Name: seven_seg_scan_n

Overview:
- Parametrised, time-multiplexed driver for an N-digit common-anode seven-segment display, replacing the fixed 8-digit scanner.
- Adds the following over the fixed scanner:
  - synchronous reset
  - per-digit decimal points and digit enables
  - frame-coherent value snapshot
  - leading-zero blanking
  - anti-ghosting blank interval
  - PWM brightness control
- Sits between the accelerometer data path (hex value source) and the board's anode, segment and dp pins.

Parameters:
- NUM_DIGITS, 8, number of digits scanned (1..16).
- SLOT_LOG2, 17, log2 of clock cycles per digit slot (SLOT_CYCLES = 2**SLOT_LOG2).
- BLANK_CYCLES, 64, cycles at the start of each slot with all anodes off (< SLOT_CYCLES/2).
- BRIGHT_W, 4, width of brightness control.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- value  in  4*NUM_DIGITS  hex digits; digit i = value[4i+3:4i]; digit 0 is rightmost
- dp_in  in  NUM_DIGITS  decimal point request per digit, active-high
- digit_en  in  NUM_DIGITS  per-digit enable, active-high; disabled digit stays dark
- lz_blank  in  1  suppress leading zeros when high
- brightness  in  BRIGHT_W  duty control; 0 = dimmest, all-ones = full
- disp_on  in  1  global enable; low forces all anodes off
- anodes  out  NUM_DIGITS  active-low anode drives
- seg  out  7  active-low segments {g,f,e,d,c,b,a}
- dp  out  1  active-low decimal point
- frame_start  out  1  one-cycle pulse when the snapshot is taken

Behaviour:
- Reset (rst=1 at a clk edge):
  - slot_cnt=0, idx=0, snapshot registers=0.
  - anodes=all 1, seg=7'h7F, dp=1, frame_start=0.
- Counters:
  - slot_cnt (SLOT_LOG2 bits) increments every cycle.
  - On wrap (all-ones -> 0), idx increments.
  - idx wraps from NUM_DIGITS-1 to 0. Non-power-of-two NUM_DIGITS must wrap correctly; idx never exceeds NUM_DIGITS-1.
- Snapshot:
  - Taken in the cycle where idx==0 and slot_cnt==0, and in the first cycle after reset deassert.
  - Latches value, dp_in, digit_en and lz_blank.
  - brightness and disp_on are NOT snapshotted; they take effect within one cycle.
  - frame_start pulses high in the snapshot cycle.
  - Input changes mid-frame are invisible until the next frame.
- Leading-zero blanking:
  - Computed from the snapshot.
  - Digit i is blanked if lz_blank=1, all digits j>=i are 0, and i>0.
  - Digit 0 is always shown; value 0 displays a single "0".
  - A blanked digit still shows its dp if requested.
- Anode on condition for idx: disp_on & digit_en_snap[idx] & (slot_cnt >= BLANK_CYCLES) & (phase <= brightness), where phase = slot_cnt[SLOT_LOG2-1 -: BRIGHT_W].
  - brightness all-ones gives full on time minus the blank interval.
  - brightness 0 gives 1/2**BRIGHT_W duty.
- Segments:
  - Hex decode 0..F uses the standard active-low patterns (0 = 7'h40, 8 = 7'h00, F = 7'h0E).
  - Lz-blanked digit gives seg = 7'h7F.
  - dp = ~dp_snap[idx].
  - When the anode is off, seg=7'h7F and dp=1 so no stale pattern is visible.
- Latency: all outputs are registered, one cycle after the counter state that selects them. At most one anode is low in any cycle.
- Reset mid-frame: outputs go dark on the next edge. Scanning restarts from idx=0 with a fresh snapshot.

Decomposition:
- Package seven_seg_pkg:
  - SEG_BLANK = 7'h7F
  - hex_to_seg function (4b -> 7b active-low)
  - seg_t typedef (logic [6:0])
- Sub-module seven_seg_decoder: combinational hex_to_seg plus blank override, reused by future display blocks.
- Counters, snapshot, lz logic and output registers stay in the top level.

Test Plan (NUM_DIGITS=4, SLOT_LOG2=4, BLANK_CYCLES=2, BRIGHT_W=2 unless noted):
- Reset then value=16'h1A3F, all enables, brightness=3 -> in each slot anodes low for cycles 2..15 only, in order 1110,1101,1011,0111; seg in that order 7'h0E, 7'h30, 7'h08, 7'h79; frame_start every 64 cycles.
- value=16'h0050, lz_blank=1 -> digits 3 and 2 show seg=7'h7F, digit 1 = 7'h12, digit 0 = 7'h40; with value=0 only digit 0 shows 7'h40.
- Change value from 16'h1111 to 16'h2222 at idx=2 mid-frame -> digits 2 and 3 still show "1" until the next frame_start, then "2".
- brightness=0 -> anode low only for slot cycles 2..3; brightness=1 -> cycles 2..7; disp_on=0 -> anodes stay 4'hF, seg=7'h7F, counters keep running.
- digit_en=4'b1011, dp_in=4'b0010 -> digit 2 never lit; dp=0 only during digit 1's on window.
- NUM_DIGITS=3 -> idx sequence 0,1,2,0; assert rst at idx=1 slot_cnt=9 -> outputs dark next cycle, scan restarts at idx=0 with a new snapshot.
